// File: rtl/lottery_pkg.sv
// Shared definitions for the lottery draw engine: FSM encoding, LFSR defaults
// and the Galois step used by the LFSR sub-module.
package lottery_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_OPEN    = 2'd0;
    localparam state_t ST_SPIN    = 2'd1;
    localparam state_t ST_PRESENT = 2'd2;
    localparam state_t ST_DONE    = 2'd3;

    localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    // Right-shifting Galois step; operands are zero-extended so any width up to 32 works.
    function automatic logic [31:0] lfsr_step(input logic [31:0] value, input logic [31:0] taps);
        return (value >> 1) ^ (value[0] ? taps : 32'd0);
    endfunction

endpackage

// File: rtl/lottery_lfsr.sv
// Galois LFSR that free-runs every cycle, optionally perturbed by an XOR term,
// and never settles on the all-zero lock-up state.
module lottery_lfsr
    import lottery_pkg::*;
#(
    parameter int                LFSR_W = 16,
    parameter int                OUT_W  = 5,
    parameter logic [LFSR_W-1:0] TAPS   = LFSR_W'(DEFAULT_TAPS),
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [LFSR_W-1:0] load_xor,
    output logic [OUT_W-1:0]  value
);

    logic [LFSR_W-1:0] value_reg;
    logic [31:0]       value_next;

    // Zero check runs on the full-width result; the bits above LFSR_W are always zero.
    always_comb begin
        value_next = lfsr_step(32'(value_reg), 32'(TAPS));
        if (load_en) begin
            value_next = value_next ^ 32'(load_xor);
        end
        if (value_next == 32'd0) begin
            value_next = 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_reg <= SEED;
        end else begin
            value_reg <= value_next[LFSR_W-1:0];
        end
    end

    assign value = value_reg[OUT_W-1:0];

endmodule

// File: rtl/lottery_draw.sv
// Multi-winner lottery: entrants register an eligibility bit, then distinct
// eligible entries are drawn by LFSR rejection sampling and handed out on valid/ack.
module lottery_draw
    import lottery_pkg::*;
#(
    parameter int                MAX_ENTRIES = 32,
    parameter int                ID_W        = $clog2(MAX_ENTRIES),
    parameter int                NUM_WINNERS = 1,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            write,
    input  logic            luckybit,
    input  logic            stop,
    input  logic            restart,
    input  logic            winner_ack,
    output logic [ID_W:0]   id,
    output logic            full,
    output logic [ID_W-1:0] winner,
    output logic            winner_valid,
    output logic            no_winner,
    output logic            draw_done,
    output logic            busy
);

    state_t                 state_reg;
    logic [ID_W:0]          id_reg;
    logic [ID_W:0]          elig_reg;
    logic [ID_W:0]          win_cnt_reg;
    logic [MAX_ENTRIES-1:0] entry_reg;
    logic [MAX_ENTRIES-1:0] drawn_reg;
    logic [ID_W-1:0]        winner_reg;
    logic                   winner_valid_reg;
    logic                   no_winner_reg;
    logic                   draw_done_reg;

    logic                   full_c;
    logic                   accept_wr;
    logic [ID_W:0]          elig_next;
    logic [ID_W-1:0]        candidate;
    logic                   cand_ok;
    logic                   take;
    logic                   clear_round;
    logic                   round_over;
    logic [LFSR_W-1:0]      load_xor;

    assign full_c      = (id_reg == (ID_W+1)'(MAX_ENTRIES));
    assign accept_wr   = (state_reg == ST_OPEN) && write && !full_c;
    assign elig_next   = elig_reg + ((accept_wr && luckybit) ? (ID_W+1)'(1) : (ID_W+1)'(0));
    assign load_xor    = LFSR_W'(luckybit) ^ (LFSR_W'(id_reg) << 1);

    // Out-of-range candidates are rejected by the id compare before the table bits matter.
    assign cand_ok     = ({1'b0, candidate} < id_reg) && entry_reg[candidate] && !drawn_reg[candidate];
    assign take        = (state_reg == ST_SPIN) && cand_ok;
    assign clear_round = (state_reg == ST_DONE) && restart;
    assign round_over  = (win_cnt_reg == (ID_W+1)'(NUM_WINNERS)) || (win_cnt_reg == elig_reg);

    lottery_lfsr #(
        .LFSR_W (LFSR_W),
        .OUT_W  (ID_W),
        .TAPS   (LFSR_TAPS),
        .SEED   (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load_en  (accept_wr),
        .load_xor (load_xor),
        .value    (candidate)
    );

    generate
        for (genvar gi = 0; gi < MAX_ENTRIES; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (reset || clear_round) begin
                    entry_reg[gi] <= 1'b0;
                    drawn_reg[gi] <= 1'b0;
                end else begin
                    if (accept_wr && (id_reg == (ID_W+1)'(gi))) begin
                        entry_reg[gi] <= luckybit;
                    end
                    if (take && (candidate == ID_W'(gi))) begin
                        drawn_reg[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= ST_OPEN;
            id_reg           <= '0;
            elig_reg         <= '0;
            win_cnt_reg      <= '0;
            winner_reg       <= '0;
            winner_valid_reg <= 1'b0;
            no_winner_reg    <= 1'b0;
            draw_done_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_OPEN: begin
                    if (accept_wr) begin
                        id_reg   <= id_reg + (ID_W+1)'(1);
                        elig_reg <= elig_next;
                    end
                    // A write in the same cycle as stop is counted before deciding.
                    if (stop || full_c) begin
                        if (elig_next == '0) begin
                            state_reg     <= ST_DONE;
                            no_winner_reg <= 1'b1;
                            draw_done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SPIN;
                        end
                    end
                end
                ST_SPIN: begin
                    if (cand_ok) begin
                        winner_reg       <= candidate;
                        win_cnt_reg      <= win_cnt_reg + (ID_W+1)'(1);
                        winner_valid_reg <= 1'b1;
                        state_reg        <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (winner_ack) begin
                        winner_valid_reg <= 1'b0;
                        if (round_over) begin
                            state_reg     <= ST_DONE;
                            draw_done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_SPIN;
                        end
                    end
                end
                ST_DONE: begin
                    if (restart) begin
                        id_reg        <= '0;
                        elig_reg      <= '0;
                        win_cnt_reg   <= '0;
                        no_winner_reg <= 1'b0;
                        draw_done_reg <= 1'b0;
                        state_reg     <= ST_OPEN;
                    end
                end
                default: state_reg <= ST_OPEN;
            endcase
        end
    end

    assign id           = id_reg;
    assign full         = full_c;
    assign winner       = winner_reg;
    assign winner_valid = winner_valid_reg;
    assign no_winner    = no_winner_reg;
    assign draw_done    = draw_done_reg;
    assign busy         = (state_reg == ST_SPIN) || (state_reg == ST_PRESENT);

endmodule

// File: tb/tb_lottery_draw.sv
// Directed bench for lottery_draw: two 8-entry instances (1 and 3 winners) share
// stimulus; a vector table covers registration, the rest are hand sequences.
`timescale 1ns/1ps
module tb_lottery_draw;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b0, write = 1'b0, luckybit = 1'b0, stop = 1'b0;
    logic restart = 1'b0, winner_ack = 1'b0;

    logic [3:0] id_a, id_b;
    logic [2:0] winner_a, winner_b;
    logic full_a, full_b, wv_a, wv_b, nw_a, nw_b, dd_a, dd_b, busy_a, busy_b;

    lottery_draw #(.MAX_ENTRIES(8), .NUM_WINNERS(1)) dut_a (
        .clk(clk), .reset(reset), .write(write), .luckybit(luckybit), .stop(stop),
        .restart(restart), .winner_ack(winner_ack), .id(id_a), .full(full_a),
        .winner(winner_a), .winner_valid(wv_a), .no_winner(nw_a),
        .draw_done(dd_a), .busy(busy_a)
    );

    lottery_draw #(.MAX_ENTRIES(8), .NUM_WINNERS(3)) dut_b (
        .clk(clk), .reset(reset), .write(write), .luckybit(luckybit), .stop(stop),
        .restart(restart), .winner_ack(winner_ack), .id(id_b), .full(full_b),
        .winner(winner_b), .winner_valid(wv_b), .no_winner(nw_b),
        .draw_done(dd_b), .busy(busy_b)
    );

    bit use_b = 1'b0;
    logic [3:0]  s_id;
    logic [2:0]  s_winner;
    logic [15:0] s_lfsr;
    logic s_full, s_wv, s_nw, s_dd, s_busy;

    always_comb begin
        s_id     = use_b ? id_b     : id_a;
        s_winner = use_b ? winner_b : winner_a;
        s_full   = use_b ? full_b   : full_a;
        s_wv     = use_b ? wv_b     : wv_a;
        s_nw     = use_b ? nw_b     : nw_a;
        s_dd     = use_b ? dd_b     : dd_a;
        s_busy   = use_b ? busy_b   : busy_a;
        s_lfsr   = use_b ? dut_b.u_lfsr.value_reg : dut_a.u_lfsr.value_reg;
    end

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit rst, wr, lb, stp;
        int e_id, e_full, e_busy, e_nw, e_dd;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit rst, input bit wr, input bit lb, input bit stp,
                       input int e_id, input int e_full, input int e_busy,
                       input int e_nw, input int e_dd);
        vec_t v;
        v.rst = rst; v.wr = wr; v.lb = lb; v.stp = stp;
        v.e_id = e_id; v.e_full = e_full; v.e_busy = e_busy; v.e_nw = e_nw; v.e_dd = e_dd;
        vt.push_back(v);
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            reset = vt[i].rst; write = vt[i].wr; luckybit = vt[i].lb; stop = vt[i].stp;
            step();
            chk($sformatf("v%0d_id", i),   int'(s_id),   vt[i].e_id);
            chk($sformatf("v%0d_full", i), int'(s_full), vt[i].e_full);
            chk($sformatf("v%0d_busy", i), int'(s_busy), vt[i].e_busy);
            chk($sformatf("v%0d_nw", i),   int'(s_nw),   vt[i].e_nw);
            chk($sformatf("v%0d_dd", i),   int'(s_dd),   vt[i].e_dd);
        end
        reset = 1'b0; write = 1'b0; luckybit = 1'b0; stop = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic write_entry(input bit lb);
        write = 1'b1; luckybit = lb;
        step();
        write = 1'b0; luckybit = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic ack();
        winner_ack = 1'b1;
        step();
        winner_ack = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int c = 0;
        while (!s_wv && c < 2000) begin
            step();
            c++;
        end
        chk({name, "_valid"}, int'(s_wv), 1);
    endtask

    task automatic check_reset_state(input string name);
        chk({name, "_id"},     int'(s_id),     0);
        chk({name, "_full"},   int'(s_full),   0);
        chk({name, "_winner"}, int'(s_winner), 0);
        chk({name, "_wv"},     int'(s_wv),     0);
        chk({name, "_nw"},     int'(s_nw),     0);
        chk({name, "_dd"},     int'(s_dd),     0);
        chk({name, "_busy"},   int'(s_busy),   0);
        chk({name, "_lfsr"},   int'(s_lfsr),   int'(16'hACE1));
    endtask

    // Draws n winners from mask, holding ack off for five cycles on each.
    task automatic draw_n(input string name, input bit [7:0] mask, input int n);
        bit [7:0] seen = 8'h00;
        int w0;
        for (int k = 0; k < n; k++) begin
            wait_valid($sformatf("%s_w%0d", name, k));
            w0 = int'(s_winner);
            chk($sformatf("%s_w%0d_eligible", name, k), int'(mask[s_winner]), 1);
            chk($sformatf("%s_w%0d_distinct", name, k), int'(seen[s_winner]), 0);
            seen[s_winner] = 1'b1;
            for (int h = 0; h < 5; h++) begin
                step();
                chk($sformatf("%s_w%0d_hold%0d", name, k, h), int'({s_wv, s_winner}), 8 + w0);
            end
            ack();
            chk($sformatf("%s_w%0d_wv_clr", name, k), int'(s_wv), 0);
            chk($sformatf("%s_w%0d_dd", name, k), int'(s_dd), (k == n - 1) ? 1 : 0);
        end
        chk({name, "_busy_end"}, int'(s_busy), 0);
    endtask

    initial begin
        bit seen_v;

        // Luckybits 1,0,1,1,0 then stop (indices 0..6)
        add(1,0,0,0, 0,0,0,0,0);
        add(0,1,1,0, 1,0,0,0,0);
        add(0,1,0,0, 2,0,0,0,0);
        add(0,1,1,0, 3,0,0,0,0);
        add(0,1,1,0, 4,0,0,0,0);
        add(0,1,0,0, 5,0,0,0,0);
        add(0,0,0,1, 5,0,1,0,0);
        // No eligible entrant (indices 7..11)
        add(1,0,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,0);
        add(0,1,0,0, 2,0,0,0,0);
        add(0,1,0,0, 3,0,0,0,0);
        add(0,0,0,1, 3,0,0,1,1);
        // Fill all 8 slots, then an ignored 9th write (indices 12..21)
        add(1,0,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,0,0,0,0);
        add(0,1,1,0, 2,0,0,0,0);
        add(0,1,0,0, 3,0,0,0,0);
        add(0,1,0,0, 4,0,0,0,0);
        add(0,1,1,0, 5,0,0,0,0);
        add(0,1,0,0, 6,0,0,0,0);
        add(0,1,0,0, 7,0,0,0,0);
        add(0,1,1,0, 8,1,0,0,0);
        add(0,1,1,0, 8,1,1,0,0);

        repeat (2) @(posedge clk);
        #1;

        // Single winner from {0,2,3}
        use_b = 1'b0;
        apply(0, 6);
        chk("t1_wv_after_stop", int'(s_wv), 0);
        wait_valid("t1");
        chk("t1_eligible", int'(s_winner == 3'd0 || s_winner == 3'd2 || s_winner == 3'd3), 1);
        chk("t1_busy", int'(s_busy), 1);
        ack();
        chk("t1_wv_clr", int'(s_wv), 0);
        chk("t1_dd", int'(s_dd), 1);
        chk("t1_busy_clr", int'(s_busy), 0);

        // Zero eligible: straight to DONE, never a valid winner
        apply(7, 11);
        seen_v = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (s_wv) seen_v = 1'b1;
        end
        chk("t2_never_valid", int'(seen_v), 0);
        chk("t2_nw_held", int'(s_nw), 1);

        // Auto-draw on full from {1,4,7}
        apply(12, 21);
        wait_valid("t3");
        chk("t3_eligible", int'(s_winner == 3'd1 || s_winner == 3'd4 || s_winner == 3'd7), 1);
        chk("t3_id", int'(s_id), 8);
        ack();
        chk("t3_dd", int'(s_dd), 1);

        // Three winners from 4 eligible of 6, then 2 winners from 2 eligible
        use_b = 1'b1;
        do_reset();
        write_entry(1); write_entry(1); write_entry(0);
        write_entry(1); write_entry(0); write_entry(1);
        chk("t4a_id", int'(s_id), 6);
        pulse_stop();
        draw_n("t4a", 8'b0010_1011, 3);
        do_reset();
        write_entry(0); write_entry(1); write_entry(0);
        write_entry(0); write_entry(1); write_entry(0);
        pulse_stop();
        draw_n("t4b", 8'b0001_0010, 2);

        // Reset during SPIN and during PRESENT
        use_b = 1'b0;
        do_reset();
        write_entry(1); write_entry(1);
        pulse_stop();
        chk("t5_spin_busy", int'(s_busy), 1);
        do_reset();
        check_reset_state("t5_spin");
        write_entry(1); write_entry(0);
        pulse_stop();
        wait_valid("t5_pre");
        do_reset();
        check_reset_state("t5_present");

        // Restart: only slot 0 eligible in both rounds, so a stale drawn mark would stall
        write_entry(1); write_entry(0);
        pulse_stop();
        wait_valid("t6a");
        chk("t6a_winner", int'(s_winner), 0);
        ack();
        chk("t6a_dd", int'(s_dd), 1);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("t6_restart_id", int'(s_id), 0);
        chk("t6_restart_dd", int'(s_dd), 0);
        chk("t6_restart_busy", int'(s_busy), 0);
        write_entry(1); write_entry(0);
        chk("t6_id", int'(s_id), 2);
        pulse_stop();
        wait_valid("t6b");
        chk("t6b_winner", int'(s_winner), 0);
        ack();
        chk("t6b_dd", int'(s_dd), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
